// File: rtl/maquina_cafe_multi.sv
// Multi-recipe capsule coffee machine controller: heat-up, recipe selection,
// capsule validation, timed pump extraction, water tank level and brew counter.
module maquina_cafe_multi #(
  parameter int                              N_RECEITAS    = 4,
  parameter int                              TEMPO_W       = 4,
  parameter logic [N_RECEITAS*TEMPO_W-1:0]   TEMPOS        = {4'd0, 4'd7, 4'd5, 4'd3},
  parameter int                              AQUEC_CICLOS  = 4,
  parameter int                              TANQUE_DOSES  = 2,
  parameter logic [3:0]                      CODIGO_VALIDO = 4'b0010,
  localparam int                             SEL_W         = $clog2(N_RECEITAS),
  localparam int                             NIVEL_W       = $clog2(TANQUE_DOSES + 1),
  localparam int                             HEAT_W        = $clog2(AQUEC_CICLOS + 1)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Power,
  input  logic               Start,
  input  logic               Refill,
  input  logic [SEL_W-1:0]   Seletor,
  input  logic [3:0]         CodigoCapsula,
  output logic               BombaAgua,
  output logic               Termobloco,
  output logic [TEMPO_W-1:0] TempoDeAgua,
  output logic [2:0]         EstadoAtual,
  output logic [NIVEL_W-1:0] NivelAgua,
  output logic [7:0]         CafesServidos
);

  typedef enum logic [2:0] {
    DESLIGADO    = 3'd0,
    AQUECER      = 3'd1,
    PRONTO       = 3'd2,
    EXTRAIR      = 3'd3,
    SEM_AGUA     = 3'd4,
    ERRO_CAPSULA = 3'd5
  } estado_t;

  localparam logic [NIVEL_W-1:0] NIVEL_CHEIO = NIVEL_W'(TANQUE_DOSES);
  localparam logic [HEAT_W-1:0]  HEAT_CARGA  = HEAT_W'(AQUEC_CICLOS);

  estado_t              state_q, state_d;
  logic [HEAT_W-1:0]    heat_q, heat_d;
  logic [TEMPO_W-1:0]   tempo_q, tempo_d;
  logic [NIVEL_W-1:0]   nivel_q, nivel_d;
  logic [7:0]           cafes_q, cafes_d;
  logic                 bomba_q, bomba_d;
  logic                 termo_q, termo_d;
  logic                 start_q;
  logic                 start_edge;
  logic [TEMPO_W-1:0]   tempo_sel;

  assign start_edge = Start & ~start_q;

  // Out-of-range selector values leave tempo_sel at 0, which reads as a disabled recipe.
  always_comb begin
    tempo_sel = '0;
    for (int i = 0; i < N_RECEITAS; i++) begin
      if (Seletor == SEL_W'(i)) tempo_sel = TEMPOS[i*TEMPO_W +: TEMPO_W];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    heat_d  = heat_q;
    tempo_d = tempo_q;
    nivel_d = nivel_q;
    cafes_d = cafes_q;
    bomba_d = bomba_q;

    if (!Power) begin
      state_d = DESLIGADO;
      heat_d  = '0;
      tempo_d = '0;
      bomba_d = 1'b0;
    end else begin
      case (state_q)
        DESLIGADO: begin
          state_d = AQUECER;
          heat_d  = HEAT_CARGA;
        end
        AQUECER: begin
          if (heat_q <= HEAT_W'(1)) begin
            state_d = PRONTO;
            heat_d  = '0;
          end else begin
            heat_d = heat_q - HEAT_W'(1);
          end
        end
        PRONTO: begin
          if (Refill) nivel_d = NIVEL_CHEIO;
          if (start_edge && tempo_sel != '0) begin
            if (CodigoCapsula != CODIGO_VALIDO) begin
              state_d = ERRO_CAPSULA;
            end else if (nivel_q == '0) begin
              state_d = SEM_AGUA;
            end else begin
              state_d = EXTRAIR;
              tempo_d = tempo_sel;
              bomba_d = 1'b1;
            end
          end
        end
        EXTRAIR: begin
          // Brew completes on the edge that sees the last remaining pump cycle.
          if (tempo_q <= TEMPO_W'(1)) begin
            state_d = PRONTO;
            tempo_d = '0;
            bomba_d = 1'b0;
            if (nivel_q != '0)    nivel_d = nivel_q - NIVEL_W'(1);
            if (cafes_q != 8'hFF) cafes_d = cafes_q + 8'd1;
          end else begin
            tempo_d = tempo_q - TEMPO_W'(1);
          end
        end
        SEM_AGUA: begin
          if (Refill) begin
            nivel_d = NIVEL_CHEIO;
            state_d = PRONTO;
          end
        end
        ERRO_CAPSULA: begin
          if (Refill) nivel_d = NIVEL_CHEIO;
          if (CodigoCapsula == CODIGO_VALIDO) state_d = PRONTO;
        end
        default: begin
          state_d = DESLIGADO;
          heat_d  = '0;
          tempo_d = '0;
          bomba_d = 1'b0;
        end
      endcase
    end

    termo_d = (state_d != DESLIGADO);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= DESLIGADO;
      heat_q  <= '0;
      tempo_q <= '0;
      nivel_q <= NIVEL_CHEIO;
      cafes_q <= '0;
      bomba_q <= 1'b0;
      termo_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      heat_q  <= heat_d;
      tempo_q <= tempo_d;
      nivel_q <= nivel_d;
      cafes_q <= cafes_d;
      bomba_q <= bomba_d;
      termo_q <= termo_d;
      start_q <= Start;
    end
  end

  assign BombaAgua     = bomba_q;
  assign Termobloco    = termo_q;
  assign TempoDeAgua   = tempo_q;
  assign EstadoAtual   = state_q;
  assign NivelAgua     = nivel_q;
  assign CafesServidos = cafes_q;

endmodule
